// File: rtl/mul_cell_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_cell_sequencer                                                         |
// | Runs a 32x32 multiply through the three-partial-product 16x16 cell.        |
// | Optional macro MUL_SEQ_HIGH_WORD_EN adds the high-word ops (MULX*).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_cell_sequencer #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_res_data,
  output logic [31:0] o_cell_src1,
  output logic [31:0] o_cell_src2,
  output logic        o_cell_en,
  input  logic [31:0] i_cell_p1,
  input  logic [31:0] i_cell_p2,
  input  logic [31:0] i_cell_p3
);

  if (CELL_LAT < 1 || CELL_LAT > 3) begin : g_bad_cell_lat
    $error("mul_cell_sequencer: CELL_LAT must be in 1..3");
  end

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ISSUE_LO = 3'd1;
  localparam logic [2:0] c_WAIT_LO  = 3'd2;
  localparam logic [2:0] c_CAPT_LO  = 3'd3;
`ifdef MUL_SEQ_HIGH_WORD_EN
  localparam logic [2:0] c_ISSUE_HI = 3'd4;
  localparam logic [2:0] c_WAIT_HI  = 3'd5;
  localparam logic [2:0] c_CAPT_HI  = 3'd6;
`endif
  localparam logic [2:0] c_DONE     = 3'd7;

  // Last value of the wait counter before the products are valid.
  localparam logic [1:0] c_WAIT_LAST = 2'(CELL_LAT - 2);

  logic [2:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_res_data;
  logic        r_req_ready;
  logic        r_res_valid;
  logic [32:0] w_mid;
  logic [49:0] w_lo64;

  assign w_mid  = {1'b0, i_cell_p2} + {1'b0, i_cell_p3};
  assign w_lo64 = {18'd0, i_cell_p1} + {1'b0, w_mid, 16'd0};

`ifdef MUL_SEQ_HIGH_WORD_EN
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [17:0] r_carry;
  logic [31:0] w_hi;

  // Signed corrections on top of the unsigned high word, all mod 2^32.
  always_comb begin
    w_hi = i_cell_p1 + {14'd0, r_carry};
    if ((r_op == 2'b01 || r_op == 2'b10) && r_a[31]) begin
      w_hi = w_hi - r_b;
    end
    if (r_op == 2'b01 && r_b[31]) begin
      w_hi = w_hi - r_a;
    end
  end

  assign o_cell_en = (r_state == c_ISSUE_LO) || (r_state == c_WAIT_LO) ||
                     (r_state == c_ISSUE_HI) || (r_state == c_WAIT_HI);
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{i_req_op, w_lo64[49:32]};
  assign o_cell_en     = (r_state == c_ISSUE_LO) || (r_state == c_WAIT_LO);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= 2'd0;
      r_src1      <= 32'd0;
      r_src2      <= 32'd0;
      r_res_data  <= 32'd0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
`ifdef MUL_SEQ_HIGH_WORD_EN
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_op        <= 2'd0;
      r_carry     <= 18'd0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_src1      <= i_req_a;
            r_src2      <= i_req_b;
            r_req_ready <= 1'b0;
            r_state     <= c_ISSUE_LO;
`ifdef MUL_SEQ_HIGH_WORD_EN
            r_a         <= i_req_a;
            r_b         <= i_req_b;
            r_op        <= i_req_op;
`endif
          end
        end
        c_ISSUE_LO: begin
          r_cnt   <= 2'd0;
          r_state <= (CELL_LAT > 1) ? c_WAIT_LO : c_CAPT_LO;
        end
        c_WAIT_LO: begin
          if (r_cnt == c_WAIT_LAST) begin
            r_state <= c_CAPT_LO;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        c_CAPT_LO: begin
          r_res_data <= w_lo64[31:0];
`ifdef MUL_SEQ_HIGH_WORD_EN
          r_carry    <= w_lo64[49:32];
          if (r_op == 2'b00) begin
            r_res_valid <= 1'b1;
            r_state     <= c_DONE;
          end else begin
            // Second pass: p1 becomes a_hi*b_hi, p2/p3 collapse to zero.
            r_src1  <= {16'h0, r_a[31:16]};
            r_src2  <= {16'h0, r_b[31:16]};
            r_state <= c_ISSUE_HI;
          end
`else
          r_res_valid <= 1'b1;
          r_state     <= c_DONE;
`endif
        end
`ifdef MUL_SEQ_HIGH_WORD_EN
        c_ISSUE_HI: begin
          r_cnt   <= 2'd0;
          r_state <= (CELL_LAT > 1) ? c_WAIT_HI : c_CAPT_HI;
        end
        c_WAIT_HI: begin
          if (r_cnt == c_WAIT_LAST) begin
            r_state <= c_CAPT_HI;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        c_CAPT_HI: begin
          r_res_data  <= w_hi;
          r_res_valid <= 1'b1;
          r_state     <= c_DONE;
        end
`endif
        c_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_cell_src1 = r_src1;
  assign o_cell_src2 = r_src2;

endmodule
`default_nettype wire
